// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the memory-game round sequencer
package game_pkg;

   localparam int ITEM_W_DEF = 4;

   // Encodings double as the display_state values seen by the seven-segment path.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHOW   = 3'd1,
      ST_GAP    = 3'd2,
      ST_RECALL = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronizer, debounce and press pulse for one active-low key
module key_conditioner
   import game_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 500000
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n_i,
   output logic press_o
);
   localparam int CNT_W = clog2(DEBOUNCE_TICKS + 1);

   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   // cnt_q counts consecutive synced samples that disagree with the accepted level.
   always_comb begin
      sync_d  = {sync_q[0], key_n_i};
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
         level_d = sync_q[1];
         cnt_d   = '0;
         press_d = ~sync_q[1];
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - round FSM: show items, collect guesses, emit hit/miss strobes
module game_round_sequencer
   import game_pkg::*;
#(
   parameter int SEQ_LEN        = 8,
   parameter int ITEM_W         = ITEM_W_DEF,
   parameter int SHOW_TICKS     = 25000000,
   parameter int GAP_TICKS      = 5000000,
   parameter int DEBOUNCE_TICKS = 500000,
   parameter int MAX_ROUNDS     = 10
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_key,
   input  logic              input_key,
   input  logic [ITEM_W-1:0] rand_item,
   input  logic [ITEM_W-1:0] guess,
   output logic [ITEM_W-1:0] item_out,
   output logic              item_valid,
   output logic [2:0]        display_state,
   output logic              score_valid,
   output logic              score_hit,
   output logic [3:0]        round,
   output logic              game_over
);
   localparam int TICK_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int TICK_W   = (clog2(TICK_MAX) > 0) ? clog2(TICK_MAX) : 1;
   localparam int IDX_W    = clog2(SEQ_LEN);

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    gcnt_q, gcnt_d;
   logic [ITEM_W-1:0]   slot_q [SEQ_LEN];
   logic [ITEM_W-1:0]   slot_d [SEQ_LEN];
   logic [SEQ_LEN-1:0]  used_q, used_d;
   logic [3:0]          round_q, round_d;
   logic                sv_q, sv_d;
   logic                sh_q, sh_d;
   logic                start_press, input_press;
   logic                hit;
   logic [SEQ_LEN-1:0]  hit_mask;

   key_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_start_key (
      .clk     (clk),
      .resetn  (resetn),
      .key_n_i (start_key),
      .press_o (start_press)
   );

   key_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_input_key (
      .clk     (clk),
      .resetn  (resetn),
      .key_n_i (input_key),
      .press_o (input_press)
   );

   // Lowest unused matching slot wins so duplicates are each consumed once.
   always_comb begin
      hit      = 1'b0;
      hit_mask = '0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (!hit && !used_q[i] && slot_q[i] == guess) begin
            hit         = 1'b1;
            hit_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q + 1'b1;
      idx_d   = idx_q;
      gcnt_d  = gcnt_q;
      slot_d  = slot_q;
      used_d  = used_q;
      round_d = round_q;
      sv_d    = 1'b0;
      sh_d    = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_press && !game_over) begin
               state_d   = ST_SHOW;
               idx_d     = '0;
               slot_d[0] = rand_item;
            end
         end
         ST_SHOW: begin
            if (tick_q == TICK_W'(SHOW_TICKS - 1)) begin
               if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
                  state_d = ST_RECALL;
                  gcnt_d  = '0;
                  used_d  = '0;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
               state_d       = ST_SHOW;
               idx_d         = idx_q + 1'b1;
               slot_d[idx_d] = rand_item;
            end
         end
         ST_RECALL: begin
            if (input_press) begin
               sv_d   = 1'b1;
               sh_d   = hit;
               used_d = used_q | hit_mask;
               gcnt_d = gcnt_q + 1'b1;
               if (gcnt_q == IDX_W'(SEQ_LEN - 1)) begin
                  state_d = ST_DONE;
                  round_d = (round_q == 4'(MAX_ROUNDS)) ? round_q : round_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) tick_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         idx_q   <= '0;
         gcnt_q  <= '0;
         used_q  <= '0;
         round_q <= '0;
         sv_q    <= 1'b0;
         sh_q    <= 1'b0;
         for (int i = 0; i < SEQ_LEN; i++) slot_q[i] <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         gcnt_q  <= gcnt_d;
         used_q  <= used_d;
         round_q <= round_d;
         sv_q    <= sv_d;
         sh_q    <= sh_d;
         slot_q  <= slot_d;
      end
   end

   assign item_valid    = (state_q == ST_SHOW);
   assign item_out      = item_valid ? slot_q[idx_q] : '0;
   assign display_state = state_q;
   assign score_valid   = sv_q;
   assign score_hit     = sh_q;
   assign round         = round_q;
   assign game_over     = (round_q == 4'(MAX_ROUNDS));

endmodule
